wb_clint_timer: RTL



---
 rtl/wb_clint_timer_pkg.sv | 48 ++++
 rtl/clint_prescaler.sv | 30 +++
 rtl/wb_clint_timer.sv | 108 ++++++++++
 3 files changed

// File: rtl/wb_clint_timer_pkg.sv
// Shared constants and helpers for the CLINT machine-timer Wishbone slave.
// Provides the address map, register decode and a byte-lane merge.
package wb_clint_timer_pkg;

    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;

    localparam logic [15:0] MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI    = 16'hBFFC;

    typedef enum logic [2:0] {
        RegNone,
        RegCmpLo,
        RegCmpHi,
        RegTimeLo,
        RegTimeHi
    } clint_reg_e;

    // Takes the word offset (adr[15:2]); byte-within-word bits never affect decode.
    function automatic clint_reg_e decode_offset(input logic [13:0] word_off);
        clint_reg_e reg_sel;
        reg_sel = RegNone;
        unique case (word_off)
            MTIMECMP_LO[15:2]: reg_sel = RegCmpLo;
            MTIMECMP_HI[15:2]: reg_sel = RegCmpHi;
            MTIME_LO[15:2]:    reg_sel = RegTimeLo;
            MTIME_HI[15:2]:    reg_sel = RegTimeHi;
            default:           reg_sel = RegNone;
        endcase
        return reg_sel;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk by PRESCALE and emits a one-cycle tick on the last count.
// PRESCALE = 1 ticks on every cycle.
module clint_prescaler #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_clint_timer.sv
// CLINT-style machine timer (mtime/mtimecmp) behind a single-cycle Wishbone slave.
// The 64-bit registers are exposed as non-atomic 32-bit halves.
module wb_clint_timer #(
    parameter int unsigned PRESCALE   = 50,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic                    wb_ack_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    timer_irq_o
);

    import wb_clint_timer_pkg::*;

    logic                  tick;
    logic                  request;
    logic                  wr_en;
    logic                  rd_en;
    clint_reg_e            reg_sel;

    logic                  ack_q;
    logic                  irq_q;
    logic                  irq_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [63:0]           mtime_q;
    logic [63:0]           mtime_d;
    logic [63:0]           mtime_inc;
    logic [63:0]           mtimecmp_q;
    logic [63:0]           mtimecmp_d;

    // Only adr[15:2] selects a register inside the block.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:16], wb_adr_i[1:0]};

    clint_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk_i),
        .rst  (rst_i),
        .tick (tick)
    );

    // Masking with the ack keeps a held strobe from being accepted twice.
    assign request = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en   = request & wb_we_i;
    assign rd_en   = request & ~wb_we_i;
    assign reg_sel = decode_offset(wb_adr_i[15:2]);

    always_comb begin
        mtime_inc  = tick ? mtime_q + 64'd1 : mtime_q;
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        // Written mtime bytes override the tick; unwritten bytes keep the increment.
        if (wr_en) begin
            unique case (reg_sel)
                RegCmpLo:  mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
                RegCmpHi:  mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
                RegTimeLo: mtime_d[31:0]     = byte_merge(mtime_inc[31:0], wb_dat_i, wb_sel_i);
                RegTimeHi: mtime_d[63:32]    = byte_merge(mtime_inc[63:32], wb_dat_i, wb_sel_i);
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (reg_sel)
            RegCmpLo:  rd_mux = mtimecmp_q[31:0];
            RegCmpHi:  rd_mux = mtimecmp_q[63:32];
            RegTimeLo: rd_mux = mtime_q[31:0];
            RegTimeHi: rd_mux = mtime_q[63:32];
            default:   rd_mux = '0;
        endcase
        rdata_d = rd_en ? rd_mux : rdata_q;
        irq_d   = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            ack_q      <= request;
            rdata_q    <= rdata_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = rdata_q;
    assign timer_irq_o = irq_q;

endmodule
